axis_to_pkt_conv: RTL and testbench

- Converts an AXI4-Stream ingress (TDATA/TKEEP/TLAST/TUSER/TVALID/TREADY) into the TSN native packet interface (DATA/SOF/EOF/BC/ERR with VALID/RDY).
- Parametrised successor of the fixed 32-bit stream-to-native converter.
- Adds configurable width, a DEPTH-entry elastic FIFO, true backpressure from the packet sink, and per-beat error propagation.
- Sits between the AXIS DMA/stream fabric and the TSN MAC transmit path.

---
 rtl/axis_to_pkt_conv.sv | 134 +++++++++++++
 tb/tb_axis_to_pkt_conv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_pkt_conv.sv
// axis_to_pkt_conv: AXI4-Stream ingress to TSN native packet interface.
// DEPTH-entry elastic FIFO with a registered first-word-fall-through head,
// backpressure from the packet sink and per-beat error propagation.
// Optional packet length check/truncation enabled by defining PKT_LEN_CHK_EN.
module axis_to_pkt_conv #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_BEATS = 384
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic [DATA_W-1:0]             STR_TDATA_IN,
   input  logic [DATA_W/8-1:0]           STR_TKEEP_IN,
   input  logic                          STR_TLAST_IN,
   input  logic                          STR_TUSER_IN,
   input  logic                          STR_TVALID_IN,
   output logic                          STR_RDY_IN,
   input  logic                          Pkt_RDY_OUT,
   output logic                          Pkt_VALID_OUT,
   output logic [DATA_W-1:0]             Pkt_DATA_OUT,
   output logic                          Pkt_SOF_OUT,
   output logic                          Pkt_EOF_OUT,
   output logic [$clog2(DATA_W/8)-1:0]   BC_OUT,
   output logic                          Pkt_ERR_OUT
);

   localparam int unsigned KW   = DATA_W / 8;
   localparam int unsigned KCW  = $clog2(KW + 1);
   localparam int unsigned BC_W = $clog2(KW);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned EW   = DATA_W + BC_W + 3;

   logic [EW-1:0]   mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
   logic [CW-1:0]   count, count_n;
   logic            in_pkt;

   logic [KCW-1:0]  keep_ones_c;
   logic [BC_W-1:0] bc_c;
   logic            accept_c, push_c, pop_c, sof_c, trunc_c;
   logic [EW-1:0]   in_entry_c, head_n;

`ifdef PKT_LEN_CHK_EN
   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

   typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;

   state_t          state;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] beat_num_c;
`else
   logic unused_max_beats;
   assign unused_max_beats = ^32'(MAX_BEATS);
`endif

   // Entry formatting, truncation decision and next FIFO head selection
   always_comb begin
      keep_ones_c = '0;
      for (int unsigned i = 0; i < KW; i++) begin
         keep_ones_c = keep_ones_c + KCW'(STR_TKEEP_IN[i]);
      end
      bc_c     = (keep_ones_c == '0) ? '0 : BC_W'(KCW'(KW) - keep_ones_c);
      accept_c = STR_TVALID_IN & STR_RDY_IN;
      sof_c    = ~in_pkt;
`ifdef PKT_LEN_CHK_EN
      beat_num_c = sof_c ? CNT_W'(1) : beat_cnt + CNT_W'(1);
      trunc_c    = accept_c & (state == ST_PASS) & ~STR_TLAST_IN &
                   (beat_num_c == CNT_W'(MAX_BEATS));
      push_c     = accept_c & (state == ST_PASS);
`else
      trunc_c    = 1'b0;
      push_c     = accept_c;
`endif
      in_entry_c = {STR_TDATA_IN, sof_c, STR_TLAST_IN | trunc_c,
                    (STR_TLAST_IN ? bc_c : BC_W'(0)), STR_TUSER_IN | trunc_c};
      pop_c      = Pkt_VALID_OUT & Pkt_RDY_OUT;
      count_n    = count + CW'(push_c) - CW'(pop_c);
      rd_ptr_n   = rd_ptr + PW'(pop_c);
      // Bypass the incoming beat when it lands directly in the head slot
      head_n     = (push_c && (count == CW'(pop_c))) ? in_entry_c : mem[rd_ptr_n];
   end

   // FIFO storage write
   always_ff @(posedge CLK) begin
      if (push_c) begin
         mem[wr_ptr] <= in_entry_c;
      end
   end

   // Pointers, occupancy, ready, registered output head and packet tracking
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         in_pkt        <= 1'b0;
         STR_RDY_IN    <= 1'b0;
         Pkt_VALID_OUT <= 1'b0;
         Pkt_DATA_OUT  <= '0;
         Pkt_SOF_OUT   <= 1'b0;
         Pkt_EOF_OUT   <= 1'b0;
         BC_OUT        <= '0;
         Pkt_ERR_OUT   <= 1'b0;
`ifdef PKT_LEN_CHK_EN
         state         <= ST_PASS;
         beat_cnt      <= '0;
`endif
      end else begin
         count         <= count_n;
         rd_ptr        <= rd_ptr_n;
         STR_RDY_IN    <= (count_n != CW'(DEPTH));
         Pkt_VALID_OUT <= (count_n != '0);
         if (push_c) begin
            wr_ptr <= wr_ptr + PW'(1);
            in_pkt <= ~STR_TLAST_IN & ~trunc_c;
         end
         if (count_n != '0) begin
            {Pkt_DATA_OUT, Pkt_SOF_OUT, Pkt_EOF_OUT, BC_OUT, Pkt_ERR_OUT} <= head_n;
         end
`ifdef PKT_LEN_CHK_EN
         if (push_c) begin
            beat_cnt <= beat_num_c;
         end
         case (state)
            ST_PASS: if (trunc_c) state <= ST_DROP;
            ST_DROP: if (accept_c && STR_TLAST_IN) state <= ST_PASS;
            default: state <= ST_PASS;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_axis_to_pkt_conv.sv
// Self-checking bench for axis_to_pkt_conv: directed steps plus randomized
// traffic against a queue-based reference model of the packet stream.
module tb_axis_to_pkt_conv;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int MAXB  = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct packed {
      logic [31:0] data;
      logic        sof;
      logic        eof;
      logic [1:0]  bc;
      logic        err;
   } pkt_t;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic [DW-1:0] STR_TDATA_IN;
   logic [3:0]    STR_TKEEP_IN;
   logic          STR_TLAST_IN, STR_TUSER_IN, STR_TVALID_IN, STR_RDY_IN;
   logic          Pkt_RDY_OUT, Pkt_VALID_OUT, Pkt_SOF_OUT, Pkt_EOF_OUT, Pkt_ERR_OUT;
   logic [DW-1:0] Pkt_DATA_OUT;
   logic [1:0]    BC_OUT;

   axis_to_pkt_conv #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .STR_TDATA_IN(STR_TDATA_IN), .STR_TKEEP_IN(STR_TKEEP_IN),
      .STR_TLAST_IN(STR_TLAST_IN), .STR_TUSER_IN(STR_TUSER_IN),
      .STR_TVALID_IN(STR_TVALID_IN), .STR_RDY_IN(STR_RDY_IN),
      .Pkt_RDY_OUT(Pkt_RDY_OUT), .Pkt_VALID_OUT(Pkt_VALID_OUT),
      .Pkt_DATA_OUT(Pkt_DATA_OUT), .Pkt_SOF_OUT(Pkt_SOF_OUT),
      .Pkt_EOF_OUT(Pkt_EOF_OUT), .BC_OUT(BC_OUT), .Pkt_ERR_OUT(Pkt_ERR_OUT)
   );

   always #5 CLK = ~CLK;

   int    checks = 0;
   int    failures = 0;
   beat_t txq[$];
   pkt_t  expq[$];
   pkt_t  m_last;
   logic  m_rdy, m_in_pkt, m_drop;
   int    m_beats;
   int    valid_pct, rdy_pct;
   int    dut_acc, obs_pops, obs_valid, obs_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: what the packet side must see for one accepted stream beat
   task automatic model_accept(input beat_t b);
      pkt_t e;
      e.data = b.data;
      e.sof  = !m_in_pkt;
      e.eof  = b.last;
      e.err  = b.user;
      e.bc   = (b.last && b.keep != 4'd0) ? 2'(4 - $countones(b.keep)) : 2'd0;
`ifdef PKT_LEN_CHK_EN
      if (m_drop) begin
         if (b.last) m_drop = 1'b0;
         return;
      end
      m_beats = e.sof ? 1 : m_beats + 1;
      if (m_beats == MAXB && !b.last) begin
         e.eof  = 1'b1;
         e.err  = 1'b1;
         e.bc   = 2'd0;
         m_drop = 1'b1;
      end
`endif
      m_in_pkt = !e.eof;
      expq.push_back(e);
   endtask

   task automatic check_outputs();
      chk("valid",   64'(Pkt_VALID_OUT), 64'(expq.size() != 0));
      chk("str_rdy", 64'(STR_RDY_IN),    64'(m_rdy));
      chk("data",    64'(Pkt_DATA_OUT),  64'(m_last.data));
      chk("sof",     64'(Pkt_SOF_OUT),   64'(m_last.sof));
      chk("eof",     64'(Pkt_EOF_OUT),   64'(m_last.eof));
      chk("bc",      64'(BC_OUT),        64'(m_last.bc));
      chk("err",     64'(Pkt_ERR_OUT),   64'(m_last.err));
   endtask

   task automatic cycle();
      logic  acc, pop;
      beat_t b;
      b = '0;
      b.data = $urandom;
      if (txq.size() != 0) b = txq[0];
      STR_TVALID_IN = (txq.size() != 0) && ($urandom_range(99) < valid_pct);
      STR_TDATA_IN  = b.data;
      STR_TKEEP_IN  = b.keep;
      STR_TLAST_IN  = b.last;
      STR_TUSER_IN  = b.user;
      Pkt_RDY_OUT   = ($urandom_range(99) < rdy_pct);
      #1;
      if (STR_TVALID_IN && STR_RDY_IN) dut_acc++;
      if (Pkt_VALID_OUT && Pkt_RDY_OUT) obs_pops++;
      acc = STR_TVALID_IN && m_rdy;
      pop = (expq.size() != 0) && Pkt_RDY_OUT;
      @(posedge CLK);
      if (pop) m_last = expq.pop_front();
      if (acc) begin
         void'(txq.pop_front());
         model_accept(b);
      end
      m_rdy = (expq.size() < DEPTH);
      if (expq.size() != 0) m_last = expq[0];
      #1;
      if (Pkt_VALID_OUT) obs_valid++;
      if (Pkt_VALID_OUT && Pkt_ERR_OUT) obs_err++;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((txq.size() != 0 || expq.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < budget) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d expected<%0d", n, budget);
      end
   endtask

   task automatic add_pkt(input int len, input int err_beat, input logic [3:0] last_keep);
      beat_t b;
      for (int i = 1; i <= len; i++) begin
         b.data = $urandom;
         b.last = (i == len);
         b.keep = b.last ? last_keep : 4'($urandom);
         b.user = (i == err_beat);
         txq.push_back(b);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      expq.delete();
      m_last   = '0;
      m_rdy    = 1'b0;
      m_in_pkt = 1'b0;
      m_drop   = 1'b0;
      m_beats  = 0;
   endtask

   initial begin
      beat_t b;
      int    exp_pops;
      RSTN = 1'b0;
      STR_TDATA_IN = '0; STR_TKEEP_IN = '0; STR_TLAST_IN = 1'b0;
      STR_TUSER_IN = 1'b0; STR_TVALID_IN = 1'b0; Pkt_RDY_OUT = 1'b0;
      valid_pct = 100; rdy_pct = 100;
      dut_acc = 0; obs_pops = 0; obs_valid = 0; obs_err = 0;
      model_reset();

      // Reset values
      repeat (3) @(posedge CLK);
      #1;
      check_outputs();
      @(negedge CLK);
      RSTN = 1'b1;
      cycle();

      // Single beat, keep 0011: next cycle SOF+EOF, BC=2
      b.data = 32'hA5A5_0001; b.keep = 4'b0011; b.last = 1'b1; b.user = 1'b0;
      txq.push_back(b);
      cycle();
      chk("single_valid", 64'(Pkt_VALID_OUT), 64'd1);
      chk("single_data",  64'(Pkt_DATA_OUT),  64'hA5A5_0001);
      chk("single_sofeof", 64'({Pkt_SOF_OUT, Pkt_EOF_OUT}), 64'd3);
      chk("single_bc",    64'(BC_OUT),        64'd2);
      run(2);

      // 5-beat packet, error on beat 3
      obs_valid = 0; obs_err = 0;
      add_pkt(5, 3, 4'b1111);
      run(7);
      chk("five_valid_cycles", 64'(obs_valid), 64'd5);
      chk("five_err_beats",    64'(obs_err),   64'd1);

      // Backpressure: 6 beats offered into a stalled sink
      rdy_pct = 0; dut_acc = 0;
      add_pkt(6, 0, 4'b0111);
      run(6);
      chk("bp_accepted", 64'(dut_acc),    64'd4);
      chk("bp_rdy_low",  64'(STR_RDY_IN), 64'd0);
      rdy_pct = 100;
      drain(50);

      // Back-to-back 3/1/2 packets with random sink ready
      rdy_pct = 50;
      add_pkt(3, 0, 4'b0001);
      add_pkt(1, 1, 4'b0000);
      add_pkt(2, 0, 4'b1111);
      drain(200);

      // Reset mid-packet with 3 beats buffered
      rdy_pct = 0;
      add_pkt(5, 0, 4'b1111);
      run(3);
      #2;
      RSTN = 1'b0;
      #1;
      chk("rst_valid", 64'(Pkt_VALID_OUT), 64'd0);
      chk("rst_rdy",   64'(STR_RDY_IN),    64'd0);
      chk("rst_data",  64'(Pkt_DATA_OUT),  64'd0);
      chk("rst_flags", 64'({Pkt_SOF_OUT, Pkt_EOF_OUT, BC_OUT, Pkt_ERR_OUT}), 64'd0);
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;
      rdy_pct = 100;
      cycle();
      add_pkt(2, 0, 4'b0011);
      cycle();
      chk("post_rst_sof", 64'(Pkt_SOF_OUT), 64'd1);
      drain(50);

      // Over-length packet followed by a short one
      rdy_pct = 70; obs_pops = 0;
      add_pkt(7, 0, 4'b1111);
      add_pkt(2, 0, 4'b0111);
      drain(200);
`ifdef PKT_LEN_CHK_EN
      exp_pops = 6;
`else
      exp_pops = 9;
`endif
      chk("long_pkt_out_beats", 64'(obs_pops), 64'(exp_pops));

      // Randomized traffic
      valid_pct = 80; rdy_pct = 60;
      for (int p = 0; p < 30; p++) begin
         add_pkt(int'($urandom_range(1, 6)), ($urandom_range(9) == 0) ? 1 : 0,
                 4'($urandom));
      end
      drain(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
